// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared ALU compare path.
// Each accepted op drives the ALU for one cycle, then strobes the registered result back to its owner.
module cmp_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FUNW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [FUNW-1:0]  req0_ALUFun,
  input  logic             req0_Sign,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [FUNW-1:0]  req1_ALUFun,
  input  logic             req1_Sign,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [FUNW-1:0]  alu_ALUFun,
  output logic             alu_Sign,
  input  logic             alu_S,
  output logic             rsp0_valid,
  output logic             rsp0_S,
  output logic             rsp1_valid,
  output logic             rsp1_S,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic             r_owner;
  logic             r_res;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [FUNW-1:0]  r_fun;
  logic             r_sign;

  logic w_win;
  logic w_gnt0;
  logic w_gnt1;
  logic w_resp;

  // Accept window excludes EXEC; gating on reset keeps ready low while reset is held.
  assign w_win  = reset & ~flush & (r_state != ST_EXEC);
  assign w_gnt0 = w_win & req0_valid & (~req1_valid | ~r_prio);
  assign w_gnt1 = w_win & req1_valid & (~req0_valid |  r_prio);
  assign w_resp = (r_state == ST_RESP) & ~flush;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp0_valid = w_resp & ~r_owner;
  assign rsp1_valid = w_resp &  r_owner;
  assign rsp0_S     = r_res;
  assign rsp1_S     = r_res;
  assign busy       = (r_state != ST_IDLE);
  assign alu_A      = r_a;
  assign alu_B      = r_b;
  assign alu_ALUFun = r_fun;
  assign alu_Sign   = r_sign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_res   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_fun   <= '0;
      r_sign  <= 1'b0;
    end else begin
      if (w_gnt0 | w_gnt1) begin
        r_a     <= w_gnt1 ? req1_A      : req0_A;
        r_b     <= w_gnt1 ? req1_B      : req0_B;
        r_fun   <= w_gnt1 ? req1_ALUFun : req0_ALUFun;
        r_sign  <= w_gnt1 ? req1_Sign   : req0_Sign;
        r_owner <= w_gnt1;
        r_prio  <= ~w_gnt1;
      end
      if ((r_state == ST_EXEC) && !flush) begin
        r_res <= alu_S;
      end
      // Grant implies the window is open, so it can never fire from EXEC.
      if (flush) begin
        r_state <= ST_IDLE;
      end else if (w_gnt0 | w_gnt1) begin
        r_state <= ST_EXEC;
      end else if (r_state == ST_EXEC) begin
        r_state <= ST_RESP;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule
